systolic_mm_engine: RTL and testbench

Parametrised N×N output-stationary systolic matrix-multiply engine, the next generation of the fixed 4×4 array. It computes C = A·B for an N×K by K×N operand pair streamed one K-slice per cycle. Input skewing, valid tracking, signed/unsigned mode, job control with a start/done handshake and result hold are built in. It sits between the operand buffers and the result writeback path.

---
 rtl/sa_pkg.sv | 30 +++
 rtl/sa_pe.sv | 65 ++++++
 rtl/systolic_mm_engine.sv | 161 ++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and helpers for the output-stationary systolic matrix-multiply engine.
package sa_pkg;

    localparam int unsigned DEF_N      = 4;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ACC_W  = 40;
    localparam int unsigned DEF_K_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Cycles needed for the last slice to cross the skewed array to PE(N-1,N-1).
    function automatic int unsigned flush_len(input int unsigned n);
        return 2 * n - 1;
    endfunction

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
        return lane * w;
    endfunction

    function automatic int unsigned cell_lsb(input int unsigned row, input int unsigned col,
                                             input int unsigned n, input int unsigned w);
        return (row * n + col) * w;
    endfunction

endpackage

// File: rtl/sa_pe.sv
// Processing element: forwards a east and b south, accumulates a*b when both operands are valid.
module sa_pe
    import sa_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_a,
    input  logic              i_a_vld,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_b_vld,
    output logic [DATA_W-1:0] o_a,
    output logic              o_a_vld,
    output logic [DATA_W-1:0] o_b,
    output logic              o_b_vld,
    output logic [ACC_W-1:0]  o_acc
);

    logic [DATA_W-1:0]   r_a;
    logic                r_a_vld;
    logic [DATA_W-1:0]   r_b;
    logic                r_b_vld;
    logic [ACC_W-1:0]    r_acc;
    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_b_ext;
    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W-1:0]    w_prod_ext;

    // Low 2*DATA_W bits of a product of pre-extended operands are correct in both modes.
    assign w_a_ext    = i_signed ? {{DATA_W{i_a[DATA_W-1]}}, i_a} : {{DATA_W{1'b0}}, i_a};
    assign w_b_ext    = i_signed ? {{DATA_W{i_b[DATA_W-1]}}, i_b} : {{DATA_W{1'b0}}, i_b};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = i_signed ? ACC_W'($signed(w_prod)) : ACC_W'(w_prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_a_vld <= 1'b0;
            r_b     <= '0;
            r_b_vld <= 1'b0;
            r_acc   <= '0;
        end else begin
            r_a     <= i_a;
            r_a_vld <= i_a_vld;
            r_b     <= i_b;
            r_b_vld <= i_b_vld;
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_a_vld && i_b_vld) begin
                r_acc <= r_acc + w_prod_ext;
            end
        end
    end

    assign o_a     = r_a;
    assign o_a_vld = r_a_vld;
    assign o_b     = r_b;
    assign o_b_vld = r_b_vld;
    assign o_acc   = r_acc;

endmodule

// File: rtl/systolic_mm_engine.sv
// N x N output-stationary systolic matrix multiplier with input skew, job FSM and result hold.
module systolic_mm_engine
    import sa_pkg::*;
#(
    parameter int unsigned N      = DEF_N,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned K_W    = DEF_K_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [K_W-1:0]         k_len,
    input  logic                   signed_mode,
    input  logic [N*DATA_W-1:0]    a_in,
    input  logic [N*DATA_W-1:0]    b_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   done,
    output logic [N*N*ACC_W-1:0]   result
);

    localparam int unsigned FLUSH_LAST = flush_len(N) - 1;
    localparam int unsigned FC_W       = $clog2(flush_len(N));

    state_t          r_state;
    logic [K_W-1:0]  r_klen;
    logic [K_W-1:0]  r_kcnt;
    logic [FC_W-1:0] r_fcnt;
    logic            r_signed;
    logic            r_zero_wait;
    logic            w_start;
    logic            w_accept;
    logic [K_W-1:0]  w_kcnt_nxt;

    logic [DATA_W-1:0] w_ah  [N][N+1];
    logic              w_ahv [N][N+1];
    logic [DATA_W-1:0] w_bv  [N+1][N];
    logic              w_bvv [N+1][N];
    logic [ACC_W-1:0]  w_acc [N][N];

    assign w_start    = start && (r_state == ST_IDLE);
    assign w_accept   = in_valid && (r_state == ST_LOAD);
    assign w_kcnt_nxt = r_kcnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_klen      <= '0;
            r_kcnt      <= '0;
            r_fcnt      <= '0;
            r_signed    <= 1'b0;
            r_zero_wait <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_klen   <= k_len;
                        r_signed <= signed_mode;
                        r_kcnt   <= '0;
                        r_fcnt   <= '0;
                        if (k_len == '0) begin
                            r_state     <= ST_DONE;
                            r_zero_wait <= 1'b1;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        r_kcnt <= w_kcnt_nxt;
                        if (w_kcnt_nxt == r_klen) begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (r_fcnt == FC_W'(FLUSH_LAST)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end
                default: begin
                    // An empty job lingers one extra DONE cycle so done lands one edge after start.
                    if (r_zero_wait) begin
                        r_zero_wait <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready = (r_state == ST_LOAD);
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE) && !r_zero_wait;

    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [DATA_W-1:0] r_a  [0:i];
        logic              r_av [0:i];
        logic [DATA_W-1:0] r_b  [0:i];
        logic              r_bv [0:i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int unsigned d = 0; d <= i; d++) begin
                    r_a[d]  <= '0;
                    r_av[d] <= 1'b0;
                    r_b[d]  <= '0;
                    r_bv[d] <= 1'b0;
                end
            end else begin
                r_a[0]  <= a_in[lane_lsb(i, DATA_W) +: DATA_W];
                r_av[0] <= w_accept;
                r_b[0]  <= b_in[lane_lsb(i, DATA_W) +: DATA_W];
                r_bv[0] <= w_accept;
                for (int unsigned d = 1; d <= i; d++) begin
                    r_a[d]  <= r_a[d-1];
                    r_av[d] <= r_av[d-1];
                    r_b[d]  <= r_b[d-1];
                    r_bv[d] <= r_bv[d-1];
                end
            end
        end

        assign w_ah[i][0]  = r_a[i];
        assign w_ahv[i][0] = r_av[i];
        assign w_bv[0][i]  = r_b[i];
        assign w_bvv[0][i] = r_bv[i];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            sa_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk      (clk),
                .rst      (rst),
                .i_clr    (w_start),
                .i_signed (r_signed),
                .i_a      (w_ah[i][j]),
                .i_a_vld  (w_ahv[i][j]),
                .i_b      (w_bv[i][j]),
                .i_b_vld  (w_bvv[i][j]),
                .o_a      (w_ah[i][j+1]),
                .o_a_vld  (w_ahv[i][j+1]),
                .o_b      (w_bv[i+1][j]),
                .o_b_vld  (w_bvv[i+1][j]),
                .o_acc    (w_acc[i][j])
            );

            assign result[cell_lsb(i, j, N, ACC_W) +: ACC_W] = w_acc[i][j];
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine: identity, signed/unsigned, bubbles, control corners, reset.
module tb_systolic_mm_engine;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 40;
    localparam int KW = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [KW-1:0]     k_len = '0;
    logic              signed_mode = 1'b0;
    logic [N*DW-1:0]   a_in = '0;
    logic [N*DW-1:0]   b_in = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic [N*N*AW-1:0] result;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;

    systolic_mm_engine #(
        .N      (N),
        .DATA_W (DW),
        .ACC_W  (AW),
        .K_W    (KW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .k_len       (k_len),
        .signed_mode (signed_mode),
        .a_in        (a_in),
        .b_in        (b_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hand-derived C values: 0 identity*B, 1 signed -1*2*3, 2 unsigned 65535*2*3, 3 zero.
    function automatic logic [AW-1:0] exp_c(input int mode, input int i, input int j);
        case (mode)
            0:       return AW'(4 * i + j + 1);
            1:       return 40'hFF_FFFF_FFFA;
            2:       return 40'd393210;
            default: return '0;
        endcase
    endfunction

    task automatic begin_job(input int k, input logic sgn);
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KW'(k);
        signed_mode = sgn;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0;
    endtask

    task automatic set_slice(input int mode, input int s);
        for (int l = 0; l < N; l++) begin
            if (mode == 0) begin
                a_in[l*DW +: DW] = (l == s) ? 16'd1 : 16'd0;
                b_in[l*DW +: DW] = DW'(4 * s + l + 1);
            end else begin
                a_in[l*DW +: DW] = 16'hFFFF;
                b_in[l*DW +: DW] = 16'd2;
            end
        end
    endtask

    task automatic stream(input int k, input int mode, input bit bubbles, input bit poke);
        for (int s = 0; s < k; s++) begin
            set_slice(mode, s);
            in_valid = 1'b1;
            if (poke && s == 1) begin
                start = 1'b1;
                k_len = '0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (bubbles && s < k - 1) begin
                in_valid = 1'b0;
                a_in = {N{16'hAAAA}};
                b_in = {N{16'h5555}};
                @(posedge clk); #1;
            end
        end
        in_valid = poke;
        a_in = {N{16'h7777}};
        b_in = {N{16'h3333}};
    endtask

    task automatic wait_done(input bit poke, output int lat);
        lat = -1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            start = poke && (n < 3);
            if (done) begin
                lat = cyc - t0;
                break;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_identity;
        int lat;
        begin_job(4, 1'b0);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ident_in_ready got=%b exp=1", in_ready); end
        stream(4, 0, 1'b0, 1'b0);
        wait_done(1'b0, lat);
        checks++; if (lat !== 11) begin failures++; $display("FAIL ident_latency got=%0d exp=11", lat); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (result[(i*N+j)*AW +: AW] !== exp_c(0, i, j)) begin
                    failures++;
                    $display("FAIL ident_c%0d%0d got=%h exp=%h", i, j, result[(i*N+j)*AW +: AW], exp_c(0, i, j));
                end
            end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL ident_done_pulse got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ident_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_signed_unsigned;
        int lat;
        for (int m = 1; m <= 2; m++) begin
            begin_job(3, (m == 1));
            stream(3, 1, 1'b0, 1'b0);
            wait_done(1'b0, lat);
            checks++; if (lat !== 10) begin failures++; $display("FAIL sgn%0d_latency got=%0d exp=10", m, lat); end
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    checks++;
                    if (result[(i*N+j)*AW +: AW] !== exp_c(m, i, j)) begin
                        failures++;
                        $display("FAIL sgn%0d_c%0d%0d got=%h exp=%h", m, i, j, result[(i*N+j)*AW +: AW], exp_c(m, i, j));
                    end
                end
        end
    endtask

    task automatic test_bubbles;
        int lat;
        begin_job(4, 1'b0);
        stream(4, 0, 1'b1, 1'b0);
        wait_done(1'b0, lat);
        checks++; if (lat !== 14) begin failures++; $display("FAIL bubble_latency got=%0d exp=14", lat); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (result[(i*N+j)*AW +: AW] !== exp_c(0, i, j)) begin
                    failures++;
                    $display("FAIL bubble_c%0d%0d got=%h exp=%h", i, j, result[(i*N+j)*AW +: AW], exp_c(0, i, j));
                end
            end
    endtask

    task automatic test_k_zero;
        int lat;
        begin_job(0, 1'b0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL k0_busy got=%b exp=1", busy); end
        wait_done(1'b0, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL k0_latency got=%0d exp=1", lat); end
        checks++; if (result !== '0) begin failures++; $display("FAIL k0_result got=%h exp=0", result); end
    endtask

    task automatic test_start_ignored;
        int lat;
        begin_job(4, 1'b0);
        stream(4, 0, 1'b0, 1'b1);
        wait_done(1'b1, lat);
        checks++; if (lat !== 11) begin failures++; $display("FAIL poke_latency got=%0d exp=11", lat); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (result[(i*N+j)*AW +: AW] !== exp_c(0, i, j)) begin
                    failures++;
                    $display("FAIL poke_c%0d%0d got=%h exp=%h", i, j, result[(i*N+j)*AW +: AW], exp_c(0, i, j));
                end
            end
    endtask

    task automatic test_hold;
        logic [N*N*AW-1:0] exp_flat;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                exp_flat[(i*N+j)*AW +: AW] = exp_c(0, i, j);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (result !== exp_flat || done !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d got=%h done=%b exp=%h done=0", c, result, done, exp_flat);
            end
        end
    endtask

    task automatic test_reset_midflush;
        int lat;
        begin_job(4, 1'b0);
        stream(4, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mf_busy_pre got=%b exp=1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (result !== '0) begin failures++; $display("FAIL mf_result got=%h exp=0", result); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL mf_ctrl got=busy%b rdy%b done%b exp=000", busy, in_ready, done);
        end
        @(negedge clk);
        rst = 1'b0;
        begin_job(4, 1'b0);
        stream(4, 0, 1'b0, 1'b0);
        wait_done(1'b0, lat);
        checks++; if (lat !== 11) begin failures++; $display("FAIL mf_latency got=%0d exp=11", lat); end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (result[(i*N+j)*AW +: AW] !== exp_c(0, i, j)) begin
                    failures++;
                    $display("FAIL mf_c%0d%0d got=%h exp=%h", i, j, result[(i*N+j)*AW +: AW], exp_c(0, i, j));
                end
            end
    endtask

    initial begin
        test_reset;
        test_identity;
        test_signed_unsigned;
        test_bubbles;
        test_k_zero;
        test_start_ignored;
        test_hold;
        test_reset_midflush;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
